// File: rtl/ascon_csr_pkg.sv
// Shared word map, bit positions and helpers for the ASCON Wishbone CSR block.
package ascon_csr_pkg;

    localparam int IDX_STATUS   = 0;
    localparam int IDX_CTRL     = 1;
    localparam int IDX_IRQ_STAT = 2;
    localparam int IDX_IRQ_EN   = 3;
    localparam int IDX_KEY      = 4;
    localparam int IDX_NONCE    = 8;
    localparam int IDX_BLK0     = 12;

    localparam int CTRL_START    = 15;
    localparam int CTRL_MODE_LSB = 13;
    localparam int CTRL_AD_LSB   = 8;

    localparam int ST_BUSY    = 3;
    localparam int ST_EMPTY   = 4;
    localparam int ST_FULL    = 5;
    localparam int ST_TAGV    = 6;
    localparam int ST_CNT_LSB = 8;

    localparam int IRQ_CT_AVAIL = 0;
    localparam int IRQ_TAG_DONE = 1;
    localparam int IRQ_OVERFLOW = 2;
    localparam int IRQ_W        = 3;

    typedef enum logic [1:0] {
        AEAD_ENC = 2'd0,
        AEAD_DEC = 2'd1,
        HASH     = 2'd2,
        RSVD     = 2'd3
    } mode_e;

    typedef struct packed {
        logic [6:0] blk1;
        logic [6:0] ct;
        logic [6:0] tag;
    } win_base_t;

    // Block windows are packed back to back after BLK0, each nb words wide.
    function automatic win_base_t win_bases(input int nb);
        win_base_t b;
        b.blk1 = 7'(IDX_BLK0 + nb);
        b.ct   = 7'(IDX_BLK0 + 2 * nb);
        b.tag  = 7'(IDX_BLK0 + 3 * nb);
        return b;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/ascon_ct_fifo.sv
// Ciphertext block FIFO with synchronous flush; flush overrides push and pop.
module ascon_ct_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             push_ok,
    output logic             pop_ok,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign pop_ok  = pop & ~empty & ~flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & ~flush & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/ascon_wb_csr.sv
// Wishbone B4 classic CSR slave for the ASCON core.
// Define ASCON_WB_CSR_IRQ_EN to build the IRQ_STAT/IRQ_EN registers and irq_o.
import ascon_csr_pkg::*;

module ascon_wb_csr #(
    parameter int BLOCK_W    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic [31:0]        wb_dat_o,
    input  logic [2:0]         state_i,
    input  logic [127:0]       tag_i,
    input  logic               tag_valid_i,
    input  logic [BLOCK_W-1:0] ct_block_i,
    input  logic               ct_valid_i,
    input  logic               block_request_i,
    output logic               start_o,
    output logic               busy_o,
    output logic [1:0]         mode_o,
    output logic [4:0]         ad_len_o,
    output logic [7:0]         datalen_o,
    output logic [127:0]       key_o,
    output logic [127:0]       nonce_o,
    output logic [BLOCK_W-1:0] blockout_o,
    output logic               irq_o
);

    localparam int        NB      = BLOCK_W / 32;
    localparam int        WS      = $clog2(NB);
    localparam int        CW      = $clog2(FIFO_DEPTH) + 1;
    localparam win_base_t WB      = win_bases(NB);
    localparam logic [6:0] TAG_END = WB.tag + 7'd4;

    mode_e               mode_q;
    logic [4:0]          ad_len_q;
    logic [7:0]          datalen_q;
    logic [3:0][31:0]    key_q, nonce_q, tag_q;
    logic [NB-1:0][31:0] blk0_q, blk1_q, ct_head;
    logic                tag_valid_q;

    logic [6:0]    idx;
    logic [WS-1:0] ws_blk0, ws_blk1, ws_ct;
    logic [1:0]    ws_tag;
    logic          is_key, is_nonce, is_blk0, is_blk1, is_ct, is_tag, mapped;
    logic          req, acc, wr, start_fire, pop_req;
    logic          fifo_push_ok, fifo_pop_ok, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status_w, ctrl_w, rd_data, wr_merged;
    logic          unused_adr;

    assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0], fifo_pop_ok};

    assign idx      = {1'b0, wb_adr_i[7:2]};
    assign ws_blk0  = WS'(idx - 7'(IDX_BLK0));
    assign ws_blk1  = WS'(idx - WB.blk1);
    assign ws_ct    = WS'(idx - WB.ct);
    assign ws_tag   = 2'(idx - WB.tag);
    assign is_key   = idx >= 7'(IDX_KEY)   && idx < 7'(IDX_NONCE);
    assign is_nonce = idx >= 7'(IDX_NONCE) && idx < 7'(IDX_BLK0);
    assign is_blk0  = idx >= 7'(IDX_BLK0)  && idx < WB.blk1;
    assign is_blk1  = idx >= WB.blk1 && idx < WB.ct;
    assign is_ct    = idx >= WB.ct   && idx < WB.tag;
    assign is_tag   = idx >= WB.tag  && idx < TAG_END;
    assign mapped   = idx < TAG_END;

    assign busy_o     = state_i != 3'd0;
    assign mode_o     = mode_q;
    assign ad_len_o   = ad_len_q;
    assign datalen_o  = datalen_q;
    assign key_o      = key_q;
    assign nonce_o    = nonce_q;
    assign blockout_o = block_request_i ? blk1_q : blk0_q;

    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign acc        = req & mapped;
    assign wr         = acc & wb_we_i;
    assign start_fire = wr & (idx == 7'(IDX_CTRL)) & ~busy_o & wb_sel_i[1] & wb_dat_i[CTRL_START];
    // Only a read of the top CT word retires the head block.
    assign pop_req    = acc & ~wb_we_i & is_ct & (ws_ct == WS'(NB - 1));

    ascon_ct_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_ct_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (start_fire),
        .push      (ct_valid_i),
        .push_data (ct_block_i),
        .pop       (pop_req),
        .push_ok   (fifo_push_ok),
        .pop_ok    (fifo_pop_ok),
        .head      (ct_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        status_w                      = '0;
        status_w[2:0]                 = state_i;
        status_w[ST_BUSY]             = busy_o;
        status_w[ST_EMPTY]            = fifo_empty;
        status_w[ST_FULL]             = fifo_full;
        status_w[ST_TAGV]             = tag_valid_q;
        status_w[ST_CNT_LSB +: CW]    = fifo_count;
        ctrl_w                        = '0;
        ctrl_w[CTRL_MODE_LSB +: 2]    = mode_q;
        ctrl_w[CTRL_AD_LSB +: 5]      = ad_len_q;
        ctrl_w[7:0]                   = datalen_q;
    end

`ifdef ASCON_WB_CSR_IRQ_EN
    logic [IRQ_W-1:0] irq_stat_q, irq_en_q, irq_set, irq_clr;

    always_comb begin
        irq_set               = '0;
        irq_set[IRQ_CT_AVAIL] = fifo_push_ok;
        irq_set[IRQ_TAG_DONE] = tag_valid_i;
        irq_set[IRQ_OVERFLOW] = ct_valid_i & ~fifo_push_ok & ~start_fire;
        irq_clr               = '0;
        if (wr && idx == 7'(IDX_IRQ_STAT))
            irq_clr = wb_dat_i[IRQ_W-1:0] & {IRQ_W{wb_sel_i[0]}};
        if (start_fire)
            irq_clr = '1;
    end

    // Set after clear so a same-cycle hardware event survives the W1C.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            irq_o      <= 1'b0;
        end else begin
            irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set;
            if (wr && idx == 7'(IDX_IRQ_EN))
                irq_en_q <= wr_merged[IRQ_W-1:0];
            irq_o <= |(irq_stat_q & irq_en_q);
        end
    end
`else
    logic unused_irq;
    assign unused_irq = fifo_push_ok;
    assign irq_o      = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (idx == 7'(IDX_STATUS))     rd_data = status_w;
        else if (idx == 7'(IDX_CTRL))  rd_data = ctrl_w;
`ifdef ASCON_WB_CSR_IRQ_EN
        else if (idx == 7'(IDX_IRQ_STAT)) rd_data = 32'(irq_stat_q);
        else if (idx == 7'(IDX_IRQ_EN))   rd_data = 32'(irq_en_q);
`endif
        else if (is_key)   rd_data = key_q[idx[1:0]];
        else if (is_nonce) rd_data = nonce_q[idx[1:0]];
        else if (is_blk0)  rd_data = blk0_q[ws_blk0];
        else if (is_blk1)  rd_data = blk1_q[ws_blk1];
        else if (is_ct)    rd_data = fifo_empty ? '0 : ct_head[ws_ct];
        else if (is_tag)   rd_data = tag_q[ws_tag];
    end

    assign wr_merged = merge_bytes(rd_data, wb_dat_i, wb_sel_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= '0;
            start_o     <= 1'b0;
            mode_q      <= AEAD_ENC;
            ad_len_q    <= '0;
            datalen_q   <= '0;
            key_q       <= '0;
            nonce_q     <= '0;
            blk0_q      <= '0;
            blk1_q      <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            wb_err_o <= req & ~mapped;
            start_o  <= start_fire;
            if (acc)
                wb_dat_o <= rd_data;
            // Session parameters are frozen while the core runs; data blocks are not.
            if (wr && !busy_o) begin
                if (idx == 7'(IDX_CTRL)) begin
                    mode_q    <= mode_e'(wr_merged[CTRL_MODE_LSB +: 2]);
                    ad_len_q  <= wr_merged[CTRL_AD_LSB +: 5];
                    datalen_q <= wr_merged[7:0];
                end
                if (is_key)   key_q[idx[1:0]]   <= wr_merged;
                if (is_nonce) nonce_q[idx[1:0]] <= wr_merged;
            end
            if (wr && is_blk0) blk0_q[ws_blk0] <= wr_merged;
            if (wr && is_blk1) blk1_q[ws_blk1] <= wr_merged;
            if (tag_valid_i)   tag_q <= tag_i;
            tag_valid_q <= (tag_valid_q & ~start_fire) | tag_valid_i;
        end
    end

endmodule

// File: doc/ascon_wb_csr.md
# ascon_wb_csr

Parametrised Wishbone B4 classic slave holding the control/status register file of the ASCON core. It is the next-generation host interface. It supports 64- or 128-bit data blocks (ASCON-128 / ASCON-128a) and buffers ciphertext blocks in an internal FIFO. It also adds byte-lane merging, bus error signalling, write protection while the core is busy, and an optional interrupt. It sits between the SoC Wishbone bus and the ASCON core datapath.

## Interface
- BLOCK_W, 64, core block width; 64 or 128 only; NB = BLOCK_W/32 words
- FIFO_DEPTH, 4, ciphertext FIFO depth; power of two, 2..16
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wb_adr_i  in  32  byte address; word index = wb_adr_i[7:2]
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lanes
- wb_we_i / wb_cyc_i / wb_stb_i  in  1 each  standard Wishbone qualifiers
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  transfer error (unmapped index)
- wb_dat_o  out  32  read data
- state_i  in  3  core FSM state; 0 = idle
- tag_i  in  128  tag from core; tag_valid_i  in  1  one-cycle tag strobe
- ct_block_i  in  BLOCK_W  ciphertext block; ct_valid_i  in  1  one-cycle push strobe
- block_request_i  in  1  selects BLK1 (1) or BLK0 (0) onto blockout_o
- start_o  out  1  one-cycle start pulse
- busy_o  out  1  state_i != 0, combinational
- mode_o  out  2; ad_len_o  out  5; datalen_o  out  8
- key_o, nonce_o  out  128 each; word 0 = bits [31:0]
- blockout_o  out  BLOCK_W  selected input block, combinational
- irq_o  out  1  registered interrupt

## Operation
- Word map:
  - 0 STATUS RO: [2:0] state_i; [3] busy; [4] fifo empty; [5] fifo full; [6] tag_valid; [12:8] fifo count.
  - 1 CTRL: [15] start; [14:13] mode; [12:8] ad_len; [7:0] datalen.
  - 2 IRQ_STAT W1C: [0] ct_avail; [1] tag_done; [2] overflow.
  - 3 IRQ_EN.
  - 4–7 KEY; 8–11 NONCE.
  - 12.. BLK0 (NB words); then BLK1 (NB); then CT RO (NB); then TAG RO (4).
- Indices above TAG end are unmapped: wb_err_o instead of ack, no state change.
- Writes merge per byte lane: unselected bytes keep their old value. Reads return the full word, ignoring wb_sel_i.
- Reserved bits read 0.
- Writes to RO words are acked and ignored.
- While busy, writes to CTRL/KEY/NONCE are acked and ignored. BLK0/BLK1 stay writable.
- start: a CTRL write with bit15=1 while idle gives start_o=1 for exactly the next cycle. Bit 15 always reads 0.
- The same start flushes the FIFO and clears tag_valid and IRQ_STAT.
- ct_valid_i pushes ct_block_i:
  - when full, the push is dropped and overflow is set;
  - a push while not full sets ct_avail.
- CT window reads the FIFO head. A read of the highest CT word pops the head; reads when empty return 0 and do not pop.
- A simultaneous pop and push while full both succeed, count unchanged.
- A push and pop in the same cycle as a flushing start: the flush wins.
- tag_valid_i latches tag_i into TAG and sets tag_valid and tag_done.
- A hardware set and a W1C clear of the same IRQ bit in the same cycle: the set wins.

## Timing
- Reset: all registers, FIFO pointers/count, wb_ack_o, wb_err_o, wb_dat_o, start_o and irq_o are 0.
- Bus response is registered: ack/err asserts the cycle after cyc&stb&!ack&!err, for one cycle. The next request is accepted no earlier than the cycle after ack.
- Read data is valid with ack. Register writes and pops take effect on the ack edge.
- start_o rises the cycle after the accepting edge.
- A FIFO push is visible in STATUS one cycle after ct_valid_i.
- irq_o = registered |(IRQ_STAT & IRQ_EN), one cycle after the status update.
- Reset mid-transfer: no ack is issued. The master must restart the transfer.

## Configuration
- ASCON_WB_CSR_IRQ_EN defined: IRQ_STAT, IRQ_EN and irq_o operate as above.
- Macro undefined:
  - words 2–3 read 0 and ignore writes, and are still acked;
  - irq_o is tied 0;
  - no flops are inferred for interrupt state.

## Structure
- Package ascon_csr_pkg holds:
  - fixed word indices 0–11 and the BLK0 base 12;
  - CTRL/STATUS/IRQ bit positions;
  - mode enum (AEAD_ENC, AEAD_DEC, HASH, RSVD);
  - a function returning the BLK1, CT and TAG bases from NB.
- One sub-module, ascon_ct_fifo: parameters WIDTH and DEPTH; synchronous flush; push/pop/full/empty/count outputs.

## Test plan
- BLOCK_W=64: write CTRL=0x0000_A310 with state_i=0 → start_o pulses 1 cycle; mode=1, ad_len=3, datalen=0x10; CTRL reads 0x0000_2310.
- Write KEY0=0xFFFF_FFFF, then KEY0=0x1234_5678 with sel=0b0010 → KEY0=0xFFFF_56FF. With state_i=2, a write to KEY0 is acked and KEY0 is unchanged.
- FIFO_DEPTH=4: 5 ct_valid_i pushes → count=4, full=1, overflow=1. Read the CT top word 4 times → data in push order, then empty=1; a 5th read returns 0.
- Full FIFO, pop and push in the same cycle → count stays 4; the new block is the tail.
- With the macro defined, IRQ_EN=0x2, tag_valid_i pulse → TAG words hold tag_i and irq_o rises 2 cycles after the strobe. W1C 0x2 clears irq_o.
- Access to word index 40 → wb_err_o for one cycle, no ack, no register change.
